// File: rtl/dmi_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmi_arb_pkg: DMI payload types, encodings and sizing helpers.  Rev 1.0
// ---------------------------------------------------------------------------
package dmi_arb_pkg;

  localparam int DMI_REQ_W  = 41;
  localparam int DMI_RESP_W = 34;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_RESP_OK     = 2'd0,
    DMI_RESP_RSVD   = 2'd1,
    DMI_RESP_FAILED = 2'd2,
    DMI_RESP_BUSY   = 2'd3
  } dmi_resp_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    dmi_op_e     op;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    dmi_resp_e   resp;
  } dmi_resp_t;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmi_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmi_arbiter_if: channel-side and DM-side handshake bundle of the arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
interface dmi_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int REQ_W  = 41,
  parameter int RESP_W = 34
);
  logic [NUM_CH*REQ_W-1:0]  ch_req_i;
  logic [NUM_CH-1:0]        ch_valid_i;
  logic [NUM_CH-1:0]        ch_ready_o;
  logic [NUM_CH-1:0]        ch_clear_i;
  logic [NUM_CH*RESP_W-1:0] ch_resp_o;
  logic [NUM_CH-1:0]        ch_resp_valid_o;
  logic [NUM_CH-1:0]        ch_resp_ready_i;
  logic [REQ_W-1:0]         dmi_req_o;
  logic                     dmi_req_valid_o;
  logic                     dmi_req_ready_i;
  logic [RESP_W-1:0]        dmi_resp_i;
  logic                     dmi_resp_valid_i;
  logic                     dmi_resp_ready_o;

  modport slave (
    input  ch_req_i, ch_valid_i, ch_clear_i, ch_resp_ready_i,
    input  dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
    output ch_ready_o, ch_resp_o, ch_resp_valid_o,
    output dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
  );

  modport master (
    output ch_req_i, ch_valid_i, ch_clear_i, ch_resp_ready_i,
    output dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
    input  ch_ready_o, ch_resp_o, ch_resp_valid_o,
    input  dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/dmi_arb_id_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmi_arb_id_fifo: in-flight {channel id, drop} FIFO with per-channel drop marking.  Rev 1.0
// ---------------------------------------------------------------------------
module dmi_arb_id_fifo
  import dmi_arb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int NUM_CH = 2,
  localparam int IDW   = clog2_min1(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [IDW-1:0]    push_id_i,
  input  logic              pop_i,
  input  logic [NUM_CH-1:0] mark_drop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [IDW-1:0]    head_id_o,
  output logic              head_drop_o
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IDW-1:0]   id_q [DEPTH];
  logic [DEPTH-1:0] drop_q;
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;

  // A clear in the current cycle already counts for the head being popped.
  assign head_id_o   = id_q[rd_q];
  assign head_drop_o = drop_q[rd_q] | mark_drop_i[id_q[rd_q]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      for (int i = 0; i < DEPTH; i++) id_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mark_drop_i[id_q[i]]) drop_q[i] <= 1'b1;
      end
      if (push) begin
        id_q[wr_q]   <= push_id_i;
        drop_q[wr_q] <= 1'b0;
        wr_q         <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmi_arbiter: N-channel round-robin DMI arbiter with in-order response routing.  Rev 1.0
// ---------------------------------------------------------------------------
module dmi_arbiter
  import dmi_arb_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int REQ_W            = DMI_REQ_W,
  parameter int RESP_W           = DMI_RESP_W,
  parameter int MAX_OUTSTANDING  = 2,
  parameter int RST_PULSE_CYCLES = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  dmi_arbiter_if.slave  bus,
  output logic          dmi_rst_no,
  output logic          err_o
);

  localparam int IDW = clog2_min1(NUM_CH);
  localparam int SMW = IDW + 1;
  localparam int PCW = $clog2(RST_PULSE_CYCLES + 1);

  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [REQ_W-1:0]  req_q;
  logic              req_valid_q;
  logic [NUM_CH-1:0] clr_q;
  logic [PCW-1:0]    pulse_cnt_q;
  logic              dmi_rst_n_q;
  logic              err_q;

  logic [NUM_CH-1:0] eligible;
  logic [SMW-1:0]    rr_sum;
  logic [IDW-1:0]    cand, grant_idx;
  logic              found, grant_vld;
  logic [REQ_W-1:0]  grant_req;
  logic              fifo_full, fifo_empty, head_drop, resp_ready, pop;
  logic [IDW-1:0]    head_id;

  // Round-robin pick: first eligible channel at or after the pointer.
  always_comb begin
    eligible  = bus.ch_valid_i & ~bus.ch_clear_i;
    found     = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + SMW'(k);
      if (rr_sum >= SMW'(NUM_CH)) rr_sum = rr_sum - SMW'(NUM_CH);
      cand = rr_sum[IDW-1:0];
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_vld = found && (!req_valid_q || bus.dmi_req_ready_i) && !fifo_full;
    rr_ptr_d  = (grant_idx == IDW'(NUM_CH - 1)) ? '0 : grant_idx + IDW'(1);
    grant_req = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_idx == IDW'(c)) grant_req = bus.ch_req_i[c*REQ_W +: REQ_W];
    end
    bus.ch_ready_o = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;
  end

  always_comb begin
    bus.ch_resp_valid_o = '0;
    bus.ch_resp_o       = '0;
    resp_ready          = 1'b1;
    if (!fifo_empty) begin
      resp_ready = head_drop || bus.ch_resp_ready_i[head_id];
      for (int c = 0; c < NUM_CH; c++) begin
        if (head_id == IDW'(c) && !head_drop) begin
          bus.ch_resp_valid_o[c]             = bus.dmi_resp_valid_i;
          bus.ch_resp_o[c*RESP_W +: RESP_W] = bus.dmi_resp_i;
        end
      end
    end
    pop = bus.dmi_resp_valid_i && resp_ready && !fifo_empty;
  end

  assign bus.dmi_resp_ready_o = resp_ready;
  assign bus.dmi_req_o        = req_q;
  assign bus.dmi_req_valid_o  = req_valid_q;
  assign dmi_rst_no           = dmi_rst_n_q;
  assign err_o                = err_q;

  dmi_arb_id_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .NUM_CH (NUM_CH)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (grant_vld),
    .push_id_i   (grant_idx),
    .pop_i       (pop),
    .mark_drop_i (bus.ch_clear_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_id_o   (head_id),
    .head_drop_o (head_drop)
  );

  // A granted request replaces the held one only once that one is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q       <= '0;
      req_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else if (grant_vld) begin
      req_q       <= grant_req;
      req_valid_q <= 1'b1;
      rr_ptr_q    <= rr_ptr_d;
    end else if (bus.dmi_req_ready_i) begin
      req_valid_q <= 1'b0;
    end
  end

  // Any clear rising edge (re)loads the pulse counter; output lags by a cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_q       <= '0;
      pulse_cnt_q <= '0;
      dmi_rst_n_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      clr_q <= bus.ch_clear_i;
      if (|(bus.ch_clear_i & ~clr_q)) begin
        pulse_cnt_q <= PCW'(RST_PULSE_CYCLES);
      end else if (pulse_cnt_q != '0) begin
        pulse_cnt_q <= pulse_cnt_q - PCW'(1);
      end
      dmi_rst_n_q <= (pulse_cnt_q == '0);
      if (bus.dmi_resp_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmi_arbiter: directed self-checking bench for dmi_arbiter (2 ch, depth 2, 3-cycle pulse).  Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmi_arbiter;
  import dmi_arb_pkg::*;

  localparam int NCH = 2;
  localparam int RW  = DMI_REQ_W;
  localparam int SW  = DMI_RESP_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic dmi_rst_n;
  logic err;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmi_arbiter_if #(.NUM_CH(NCH), .REQ_W(RW), .RESP_W(SW)) bus ();

  dmi_arbiter #(
    .NUM_CH           (NCH),
    .REQ_W            (RW),
    .RESP_W           (SW),
    .MAX_OUTSTANDING  (2),
    .RST_PULSE_CYCLES (3)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .dmi_rst_no (dmi_rst_n),
    .err_o      (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] mkreq(input logic [6:0] a, input logic [31:0] d, input dmi_op_e op);
    dmi_req_t r;
    r.addr = a;
    r.data = d;
    r.op   = op;
    return r;
  endfunction

  function automatic logic [SW-1:0] mkresp(input logic [31:0] d, input dmi_resp_e rs);
    dmi_resp_t r;
    r.data = d;
    r.resp = rs;
    return r;
  endfunction

  logic [RW-1:0] p0, pa, pb;
  logic [SW-1:0] r0, r1, r2;

  initial begin
    p0 = mkreq(7'h10, 32'h0, DMI_OP_READ);
    pa = mkreq(7'h11, 32'h1111_0000, DMI_OP_WRITE);
    pb = mkreq(7'h22, 32'h2222_0000, DMI_OP_WRITE);
    r0 = mkresp(32'hDEAD_BEEF, DMI_RESP_OK);
    r1 = mkresp(32'hCAFE_0001, DMI_RESP_OK);
    r2 = mkresp(32'h0BAD_0002, DMI_RESP_OK);

    bus.ch_req_i = '0;  bus.ch_valid_i = '0;  bus.ch_clear_i = '0;
    bus.ch_resp_ready_i = '0;  bus.dmi_req_ready_i = 1'b0;
    bus.dmi_resp_i = '0;  bus.dmi_resp_valid_i = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dmi_rst_n", dmi_rst_n, 1);
    chk("rst_req_valid", bus.dmi_req_valid_o, 0);
    chk("rst_req_data", bus.dmi_req_o, 0);
    chk("rst_ch_ready", bus.ch_ready_o, 0);
    chk("rst_resp_valid", bus.ch_resp_valid_o, 0);
    chk("rst_err", err, 0);
    chk("rst_resp_ready_empty", bus.dmi_resp_ready_o, 1);
    cyc(); cyc();
    rst_n = 1'b1;

    // Single channel read, response to ch0 only
    bus.ch_req_i[0 +: RW] = p0;  bus.ch_valid_i = 2'b01;  #1;
    chk("t1_grant", bus.ch_ready_o, 2'b01);
    cyc();
    bus.ch_valid_i = 2'b00;  #1;
    chk("t1_req_valid", bus.dmi_req_valid_o, 1);
    chk("t1_req_data", bus.dmi_req_o, p0);
    bus.dmi_req_ready_i = 1'b1;
    cyc();
    bus.dmi_req_ready_i = 1'b0;  #1;
    chk("t1_req_valid_fall", bus.dmi_req_valid_o, 0);
    bus.dmi_resp_i = r0;  bus.dmi_resp_valid_i = 1'b1;  bus.ch_resp_ready_i = 2'b01;  #1;
    chk("t1_resp_valid", bus.ch_resp_valid_o, 2'b01);
    chk("t1_resp_ch0", bus.ch_resp_o[0 +: SW], r0);
    chk("t1_resp_ch1_zero", bus.ch_resp_o[SW +: SW], 0);
    chk("t1_resp_ready", bus.dmi_resp_ready_o, 1);
    cyc();
    bus.dmi_resp_valid_i = 1'b0;  #1;
    chk("t1_err_clean", err, 0);

    // Both channels, immediate responses: pointer is at 1, grants 1,0,1,0
    bus.ch_req_i = {pb, pa};  bus.ch_valid_i = 2'b11;
    bus.dmi_req_ready_i = 1'b1;  bus.ch_resp_ready_i = 2'b11;  #1;
    chk("t2_g0", bus.ch_ready_o, 2'b10);
    cyc();
    bus.dmi_resp_i = r1;  bus.dmi_resp_valid_i = 1'b1;  #1;
    chk("t2_req0", bus.dmi_req_o, pb);
    chk("t2_g1", bus.ch_ready_o, 2'b01);
    chk("t2_rsp0_valid", bus.ch_resp_valid_o, 2'b10);
    chk("t2_rsp0_data", bus.ch_resp_o[SW +: SW], r1);
    cyc();
    bus.dmi_resp_i = r2;  #1;
    chk("t2_req1", bus.dmi_req_o, pa);
    chk("t2_g2", bus.ch_ready_o, 2'b10);
    chk("t2_rsp1_valid", bus.ch_resp_valid_o, 2'b01);
    chk("t2_rsp1_data", bus.ch_resp_o[0 +: SW], r2);
    cyc();  #1;
    chk("t2_req2", bus.dmi_req_o, pb);
    chk("t2_g3", bus.ch_ready_o, 2'b01);
    chk("t2_rsp2_valid", bus.ch_resp_valid_o, 2'b10);
    cyc();

    // Responses withheld: one more grant fills the FIFO, then none
    bus.dmi_resp_valid_i = 1'b0;  #1;
    chk("t2_req3", bus.dmi_req_o, pa);
    chk("t2_g4", bus.ch_ready_o, 2'b10);
    cyc();  #1;
    chk("t2_req4", bus.dmi_req_o, pb);
    chk("t2_full_no_grant", bus.ch_ready_o, 2'b00);
    cyc();  #1;
    chk("t2_full_valid_fall", bus.dmi_req_valid_o, 0);
    chk("t2_full_no_grant2", bus.ch_ready_o, 2'b00);
    bus.dmi_resp_valid_i = 1'b1;  #1;
    chk("t2_pop_head0", bus.ch_resp_valid_o, 2'b01);
    chk("t2_full_pop_no_push", bus.ch_ready_o, 2'b00);
    cyc();
    bus.dmi_resp_valid_i = 1'b0;  bus.dmi_req_ready_i = 1'b0;  #1;
    chk("t2_after_pop_grant", bus.ch_ready_o, 2'b01);
    cyc();

    // Drain the FIFO (ch1 then ch0) while ch0's request sits unaccepted
    bus.ch_valid_i = 2'b00;  bus.dmi_resp_valid_i = 1'b1;  #1;
    chk("t3_drain_head1", bus.ch_resp_valid_o, 2'b10);
    cyc();  #1;
    chk("t3_drain_head0", bus.ch_resp_valid_o, 2'b01);
    cyc();
    bus.dmi_resp_valid_i = 1'b0;

    // Backpressure: request held stable, no new grant
    bus.ch_valid_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t3_hold_valid_%0d", i), bus.dmi_req_valid_o, 1);
      chk($sformatf("t3_hold_data_%0d", i), bus.dmi_req_o, pa);
      chk($sformatf("t3_hold_no_grant_%0d", i), bus.ch_ready_o, 2'b00);
      cyc();
    end
    bus.dmi_req_ready_i = 1'b1;  #1;
    chk("t3_release_grant", bus.ch_ready_o, 2'b10);
    cyc();
    bus.ch_valid_i = 2'b00;  #1;
    chk("t3_next_req", bus.dmi_req_o, pb);
    cyc();
    bus.dmi_req_ready_i = 1'b0;  #1;
    chk("t3_valid_fall", bus.dmi_req_valid_o, 0);

    // ch1 outstanding; 1-cycle clear gives a 3-cycle reset pulse and drop
    bus.ch_resp_ready_i = 2'b00;  bus.ch_clear_i = 2'b10;  #1;
    chk("t4_rst_pre", dmi_rst_n, 1);
    cyc();
    bus.ch_clear_i = 2'b00;  #1;
    chk("t4_rst_e1", dmi_rst_n, 1);
    cyc();
    bus.dmi_resp_i = r1;  bus.dmi_resp_valid_i = 1'b1;  #1;
    chk("t4_rst_e2", dmi_rst_n, 0);
    chk("t4_drop_ready", bus.dmi_resp_ready_o, 1);
    chk("t4_drop_no_valid", bus.ch_resp_valid_o, 2'b00);
    cyc();
    bus.dmi_resp_valid_i = 1'b0;  #1;
    chk("t4_rst_e3", dmi_rst_n, 0);
    chk("t4_no_err", err, 0);
    cyc();  #1;
    chk("t4_rst_e4", dmi_rst_n, 0);
    cyc();  #1;
    chk("t4_rst_e5", dmi_rst_n, 1);

    // Second clear edge during the pulse extends it
    bus.ch_clear_i = 2'b01;
    cyc();
    bus.ch_clear_i = 2'b00;  #1;
    chk("t5_rst_e6", dmi_rst_n, 1);
    cyc();  #1;
    chk("t5_rst_e7", dmi_rst_n, 0);
    cyc();
    bus.ch_clear_i = 2'b10;  #1;
    chk("t5_rst_e8", dmi_rst_n, 0);
    cyc();
    bus.ch_clear_i = 2'b00;  #1;
    chk("t5_rst_e9", dmi_rst_n, 0);
    cyc();  #1;
    chk("t5_rst_e10", dmi_rst_n, 0);
    cyc();  #1;
    chk("t5_rst_e11", dmi_rst_n, 0);
    cyc();  #1;
    chk("t5_rst_e12", dmi_rst_n, 0);
    cyc();  #1;
    chk("t5_rst_e13", dmi_rst_n, 1);

    // Response with nothing outstanding
    bus.dmi_resp_i = r2;  bus.dmi_resp_valid_i = 1'b1;  #1;
    chk("t6_ready_empty", bus.dmi_resp_ready_o, 1);
    chk("t6_no_valid", bus.ch_resp_valid_o, 2'b00);
    chk("t6_err_not_yet", err, 0);
    cyc();
    bus.dmi_resp_valid_i = 1'b0;  #1;
    chk("t6_err_set", err, 1);
    cyc();  cyc();  #1;
    chk("t6_err_sticky", err, 1);

    // Cleared channels are never granted
    bus.ch_valid_i = 2'b11;  bus.ch_clear_i = 2'b11;  #1;
    chk("t7_all_cleared", bus.ch_ready_o, 2'b00);
    bus.ch_clear_i = 2'b01;  #1;
    chk("t7_ch0_cleared", bus.ch_ready_o, 2'b10);
    bus.ch_valid_i = 2'b00;  bus.ch_clear_i = 2'b00;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
Single-clock N-channel DMI request/response arbiter in the core clock domain, placed between the per-source DMI CDC outputs (JTAG plus future debug masters) and the debug module's single DMI port.
- Round-robin arbitration of requests onto a registered DMI request output.
- Bounded outstanding-transaction tracking, with in-order response routing back to the originating channel.
- Per-channel clear that discards that channel's in-flight responses.
- Programmable-width DMI reset pulse, generalising the single-cycle reset on clear-pending rise.

Parameters:
NUM_CH, 2, number of requesting channels (>=1)
REQ_W, 41, DMI request width (addr 7 + data 32 + op 2)
RESP_W, 34, DMI response width (data 32 + resp 2)
MAX_OUTSTANDING, 2, depth of in-flight ID FIFO (>=1)
RST_PULSE_CYCLES, 1, low time of dmi_rst_no per clear event (>=1)

Ports:
clk_i  in  1  core clock
rst_ni  in  1  reset; asynchronous, active-low
ch_req_i  in  NUM_CH*REQ_W  per-channel request payload, channel c at [c*REQ_W +: REQ_W]
ch_valid_i  in  NUM_CH  per-channel request valid
ch_ready_o  out  NUM_CH  per-channel request accepted (one-hot or zero)
ch_clear_i  in  NUM_CH  per-channel clear, level
ch_resp_o  out  NUM_CH*RESP_W  per-channel response payload
ch_resp_valid_o  out  NUM_CH  per-channel response valid
ch_resp_ready_i  in  NUM_CH  per-channel response ready
dmi_rst_no  out  1  debug-module DMI reset, active-low pulse
dmi_req_o  out  REQ_W  request to debug module
dmi_req_valid_o  out  1  request valid
dmi_req_ready_i  in  1  request ready
dmi_resp_i  in  RESP_W  response from debug module
dmi_resp_valid_i  in  1  response valid
dmi_resp_ready_o  out  1  response ready
err_o  out  1  sticky: response received with no transaction outstanding

Behaviour:
- Reset values: dmi_rst_no=1; dmi_req_valid_o=0; dmi_req_o=0; ch_ready_o=0; ch_resp_valid_o=0; err_o=0; round-robin pointer=0; FIFO empty; pulse counter=0.
- Grant condition, all must hold:
  - output slot free, i.e. (!dmi_req_valid_o || dmi_req_ready_i);
  - FIFO count < MAX_OUTSTANDING;
  - at least one channel c with ch_valid_i[c] && !ch_clear_i[c].
- Grant selection: the first eligible channel at or after the pointer, wrapping modulo NUM_CH.
- On grant g:
  - ch_ready_o[g]=1 combinationally;
  - next cycle dmi_req_o = payload of g and dmi_req_valid_o=1 (latency 1);
  - push {id=g, drop=0} to the FIFO;
  - pointer <= (g+1) mod NUM_CH.
- No push when the FIFO is full, even if a pop occurs the same cycle. This avoids a response-to-ready combinational path.
- dmi_req_valid_o/dmi_req_o stay stable until dmi_req_ready_i. A held request is never retracted, including on clear.
- dmi_req_valid_o falls the cycle after acceptance unless a new grant occurs in the acceptance cycle, which gives back-to-back throughput of 1/cycle.
- Response path, FIFO non-empty, head {h, d}:
  - when d=0, ch_resp_valid_o[h] = dmi_resp_valid_i and ch_resp_o[h] = dmi_resp_i;
  - dmi_resp_ready_o = d || ch_resp_ready_i[h];
  - pop on dmi_resp_valid_i && dmi_resp_ready_o;
  - other channels' ch_resp_valid_o = 0; ch_resp_o for non-head channels = 0.
- Response path, FIFO empty: dmi_resp_ready_o=1. A response arriving then is discarded and sets err_o=1 from the next cycle until reset.
- Clear, while ch_clear_i[c]=1:
  - channel c is never granted;
  - every FIFO entry with id=c gets drop=1 in that cycle, including the head entry being popped and the entry of a request held in the output slot.
  - Dropped responses are consumed with no ch_resp_valid_o.
- Reset pulse:
  - a rising edge of any ch_clear_i bit (per-bit edge registers) loads the counter with RST_PULSE_CYCLES on the next clock;
  - dmi_rst_no = (counter==0), registered;
  - a new edge while counting reloads the counter, extending the pulse;
  - simultaneous edges on several channels count as one event.
- Clear asserted out of reset with ch_clear_i already high: the edge registers reset to 0, so this generates a pulse.
- Simultaneous grant and pop in one cycle: count unchanged. A drop-marking and a push of the same id cannot coincide, because a cleared channel is not granted.
- Reset mid-transaction: all state returns to reset values immediately, and outstanding responses are lost. The arbiter is reset together with the DM in the system.

Decomposition:
- Package dmi_arb_pkg:
  - dmi_req_t {addr[6:0], data[31:0], op[1:0]} and dmi_resp_t {data[31:0], resp[1:0]};
  - DMI_REQ_W=41, DMI_RESP_W=34 constants;
  - op/resp encodings.
- Sub-module dmi_arb_id_fifo:
  - synchronous FIFO of {id[$clog2(NUM_CH) or 1], drop};
  - ports: push, pop, full, empty, head, plus a mark_drop vector input that sets drop on all matching entries.
- Round-robin selection stays inline.

Test Plan:
- Single channel: ch0 request addr=0x10, op=read → dmi_req_valid_o 1 cycle after ch_ready_o[0]; DM response data=0xDEADBEEF, resp=0 → appears only on ch_resp_o[0].
- Both channels valid continuously, dmi_req_ready_i=1, MAX_OUTSTANDING=2 with responses immediate → grants alternate 0,1,0,1; with responses withheld, at most 2 grants, then ch_ready_o=0 until a pop.
- Backpressure: dmi_req_ready_i=0 for 5 cycles → dmi_req_o/valid stable for all 5 cycles; no further grant occurs.
- ch1 outstanding, ch_clear_i[1] pulsed 1 cycle, RST_PULSE_CYCLES=3 → dmi_rst_no low for exactly 3 cycles starting 1 cycle after the edge; ch1's response is consumed with dmi_resp_ready_o=1 and ch_resp_valid_o[1] stays 0.
- Second clear edge during an active pulse → pulse extended to 3 cycles after the second edge.
- Response with FIFO empty → dmi_resp_ready_o=1, no ch_resp_valid_o, err_o=1 next cycle and held.
